// File: rtl/encap_seed_loader_if.sv
// rtl/encap_seed_loader_if.sv - UART byte input, seed RAM port and encap core port of the seed loader
interface encap_seed_loader_if #(
    parameter int ADDR_W = 4
) ();
    logic              rx_done;
    logic [7:0]        rx_data;
    logic              seed_wr_en;
    logic [ADDR_W-1:0] seed_addr;
    logic [31:0]       seed_wr_data;
    logic [31:0]       seed_rd_data;
    logic              seed_valid;
    logic [31:0]       seed;
    logic              encap_done;
    logic              busy;
    logic [1:0]        err;

    modport master (
        input  rx_done, rx_data, seed_rd_data, encap_done,
        output seed_wr_en, seed_addr, seed_wr_data, seed_valid, seed, busy, err
    );

    modport slave (
        output rx_done, rx_data, seed_rd_data, encap_done,
        input  seed_wr_en, seed_addr, seed_wr_data, seed_valid, seed, busy, err
    );
endinterface

// File: rtl/encap_seed_loader.sv
// rtl/encap_seed_loader.sv - TLV seed frame decoder, seed RAM packer and replay burst; optional ENCAP_LOADER_TIMEOUT_EN
module encap_seed_loader #(
    parameter int         SEED_WORDS  = 16,
    parameter int         ADDR_W      = 4,
    parameter logic [7:0] TYPE_SEED   = 8'h01,
    parameter int         TIMEOUT_CYC = 100000
) (
    input logic               clk,
    input logic               rst_n,
    encap_seed_loader_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_VALUE, S_SKIP, S_REPLAY, S_WAIT_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LP_LAST_WORD = ADDR_W'(SEED_WORDS - 1);
    localparam logic [ADDR_W:0]   LP_WORDS     = (ADDR_W + 1)'(SEED_WORDS);
    localparam logic [ADDR_W:0]   LP_RD_END    = (ADDR_W + 1)'(SEED_WORDS + 1);

    state_t            r_state;
    logic [7:0]        r_type;
    logic [7:0]        r_len_cnt;
    logic [1:0]        r_byte_cnt;
    logic [ADDR_W-1:0] r_word_cnt;
    logic [23:0]       r_shift;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wr_data;
    logic              r_valid;
    logic              r_busy;
    logic [1:0]        r_err;
    // counts replay cycles: address issue leads the forwarded word by one cycle
    logic [ADDR_W:0]   r_rd_cnt;

    logic [31:0]       w_word;
    logic [7:0]        w_len_next;

    assign w_word     = {r_shift, bus.rx_data};
    assign w_len_next = r_len_cnt - 8'd1;

`ifdef ENCAP_LOADER_TIMEOUT_EN
    localparam int             TO_W       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] LP_TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            w_in_frame;
    assign w_in_frame = (r_state == S_LEN) || (r_state == S_VALUE) || (r_state == S_SKIP);
`endif

    // frame decode, word packing, RAM write, replay sequencing and error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_type     <= '0;
            r_len_cnt  <= '0;
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_shift    <= '0;
            r_wr_en    <= 1'b0;
            r_addr     <= '0;
            r_wr_data  <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= '0;
            r_rd_cnt   <= '0;
`ifdef ENCAP_LOADER_TIMEOUT_EN
            r_to_cnt   <= '0;
`endif
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.rx_done && bus.rx_data != 8'h00) begin
                        r_type  <= bus.rx_data;
                        r_state <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (bus.rx_done) begin
                        r_len_cnt <= bus.rx_data;
                        if (bus.rx_data == 8'h00) begin
                            r_state <= S_IDLE;
                        end else if (r_type == TYPE_SEED) begin
                            r_state <= S_VALUE;
                        end else begin
                            r_state  <= S_SKIP;
                            r_err[0] <= 1'b1;
                        end
                    end
                end
                S_VALUE: begin
                    if (bus.rx_done) begin
                        r_shift    <= w_word[23:0];
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_len_cnt  <= w_len_next;
                        r_busy     <= 1'b1;
                        if (r_byte_cnt == 2'd3) begin
                            r_wr_en    <= 1'b1;
                            r_addr     <= r_word_cnt;
                            r_wr_data  <= w_word;
                            r_word_cnt <= r_word_cnt + 1'b1;
                            if (r_word_cnt == LP_LAST_WORD) begin
                                // RAM is full: leftover frame bytes are discarded
                                r_state   <= S_REPLAY;
                                r_rd_cnt  <= '0;
                                r_len_cnt <= '0;
                                if (w_len_next != 8'd0) begin
                                    r_err[1] <= 1'b1;
                                end
                            end else if (w_len_next == 8'd0) begin
                                r_state <= S_IDLE;
                            end
                        end else if (w_len_next == 8'd0) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_SKIP: begin
                    if (bus.rx_done) begin
                        r_len_cnt <= w_len_next;
                        if (w_len_next == 8'd0) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_REPLAY: begin
                    if (bus.rx_done) begin
                        r_err[1] <= 1'b1;
                    end
                    if (r_rd_cnt < LP_WORDS) begin
                        r_addr <= r_rd_cnt[ADDR_W-1:0];
                    end
                    r_valid  <= (r_rd_cnt != '0) && (r_rd_cnt <= LP_WORDS);
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                    if (r_rd_cnt == LP_RD_END) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (bus.rx_done) begin
                        r_err[1] <= 1'b1;
                    end
                    if (bus.encap_done) begin
                        r_busy     <= 1'b0;
                        r_word_cnt <= '0;
                        r_byte_cnt <= '0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
`ifdef ENCAP_LOADER_TIMEOUT_EN
            // inter-byte watchdog; only idle cycles inside a frame count
            if (w_in_frame && !bus.rx_done) begin
                if (r_to_cnt == LP_TO_LAST) begin
                    r_to_cnt   <= '0;
                    r_err[1]   <= 1'b1;
                    r_state    <= S_IDLE;
                    r_byte_cnt <= '0;
                    r_word_cnt <= '0;
                    r_busy     <= 1'b0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end
`endif
        end
    end

    assign bus.seed_wr_en   = r_wr_en;
    assign bus.seed_addr    = r_addr;
    assign bus.seed_wr_data = r_wr_data;
    assign bus.seed_valid   = r_valid;
    // RAM read data arrives one cycle after its address, aligned with r_valid
    assign bus.seed         = r_valid ? bus.seed_rd_data : 32'h0;
    assign bus.busy         = r_busy;
    assign bus.err          = r_err;
endmodule

// File: tb/tb_encap_seed_loader.sv
// tb/tb_encap_seed_loader.sv - scoreboard bench for encap_seed_loader
module tb_encap_seed_loader;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

`ifdef ENCAP_LOADER_TIMEOUT_EN
    localparam int TO_CYC = 50;
`else
    localparam int TO_CYC = 100000;
`endif

    encap_seed_loader_if #(.ADDR_W(4)) bus ();

    encap_seed_loader #(
        .SEED_WORDS(16), .ADDR_W(4), .TYPE_SEED(8'h01), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.master)
    );

    // seed RAM with registered read
    logic [31:0] ram [16];
    always @(posedge clk) begin
        if (bus.seed_wr_en) ram[bus.seed_addr] <= bus.seed_wr_data;
        bus.seed_rd_data <= ram[bus.seed_addr];
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard queues and reference model
    logic [35:0] exp_wr_q [$];
    logic [31:0] exp_seed_q [$];
    int          m_bc = 0;
    int          m_wc = 0;
    logic [31:0] m_word = '0;
    logic [31:0] m_mem [16];
    bit          m_full = 0;

    task automatic model_byte(input logic [7:0] b);
        if (!m_full) begin
            m_word = {m_word[23:0], b};
            m_bc++;
            if (m_bc == 4) begin
                exp_wr_q.push_back({4'(m_wc), m_word});
                m_mem[m_wc] = m_word;
                m_wc++;
                m_bc = 0;
                if (m_wc == 16) begin
                    for (int i = 0; i < 16; i++) exp_seed_q.push_back(m_mem[i]);
                    m_full = 1;
                end
            end
        end
    endtask

    task automatic model_clear();
        m_full = 0;
        m_wc   = 0;
        m_bc   = 0;
    endtask

    // output monitor
    int          cyc = 0;
    int          last_wr_cyc = 0;
    int          run = 0;
    int          n_wr = 0;
    logic        prev_valid = 1'b0;
    logic [35:0] e_wr;
    logic [31:0] e_seed;
    logic [31:0] cap_wr [16];

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (bus.seed_wr_en) begin
                n_wr++;
                last_wr_cyc = cyc;
                cap_wr[bus.seed_addr] = bus.seed_wr_data;
                chk("wr_valid_excl", 64'(bus.seed_valid), 64'd0);
                if (exp_wr_q.size() == 0) begin
                    chk("wr_extra", 64'(bus.seed_addr), 64'hFFFF);
                end else begin
                    e_wr = exp_wr_q.pop_front();
                    chk("wr_addr", 64'(bus.seed_addr), 64'(e_wr[35:32]));
                    chk("wr_data", 64'(bus.seed_wr_data), 64'(e_wr[31:0]));
                end
            end
            if (bus.seed_valid) begin
                if (!prev_valid) begin
                    chk("valid_lat", 64'(cyc - last_wr_cyc), 64'd2);
                    run = 0;
                end
                run++;
                if (exp_seed_q.size() == 0) begin
                    chk("seed_extra", 64'(bus.seed), 64'hFFFF_FFFF_FFFF);
                end else begin
                    e_seed = exp_seed_q.pop_front();
                    chk("seed_word", 64'(bus.seed), 64'(e_seed));
                end
            end else if (prev_valid) begin
                chk("valid_run", 64'(run), 64'd16);
            end
            prev_valid = bus.seed_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_done = 1'b1;
        bus.rx_data = b;
        @(negedge clk);
        bus.rx_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_seed_frame(input logic [7:0] len, input logic [7:0] start);
        logic [7:0] b;
        send_byte(8'h01);
        send_byte(len);
        for (int i = 0; i < int'(len); i++) begin
            b = start + 8'(i);
            model_byte(b);
            send_byte(b);
        end
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 300 && (exp_wr_q.size() + exp_seed_q.size()) > 0; i++) @(negedge clk);
        chk({tag, "_wr_left"}, 64'(exp_wr_q.size()), 64'd0);
        chk({tag, "_seed_left"}, 64'(exp_seed_q.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic done_pulse(input string tag);
        chk({tag, "_busy_before"}, 64'(bus.busy), 64'd1);
        @(negedge clk);
        bus.encap_done = 1'b1;
        @(negedge clk);
        bus.encap_done = 1'b0;
        chk({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
        model_clear();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    int w0;

    initial begin
        rst_n          = 1'b0;
        bus.rx_done    = 1'b0;
        bus.rx_data    = 8'h00;
        bus.encap_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr_en",   64'(bus.seed_wr_en),   64'd0);
        chk("rst_addr",    64'(bus.seed_addr),    64'd0);
        chk("rst_wr_data", 64'(bus.seed_wr_data), 64'd0);
        chk("rst_valid",   64'(bus.seed_valid),   64'd0);
        chk("rst_seed",    64'(bus.seed),         64'd0);
        chk("rst_busy",    64'(bus.busy),         64'd0);
        chk("rst_err",     64'(bus.err),          64'd0);
        rst_n = 1'b1;

        // single 64-byte frame
        send_seed_frame(8'h40, 8'h00);
        wait_drain("normal");
        chk("normal_word0",  64'(cap_wr[0]),  64'h0001_0203);
        chk("normal_word15", 64'(cap_wr[15]), 64'h3C3D_3E3F);
        chk("normal_err",    64'(bus.err),    64'd0);
        done_pulse("normal");

        // same seed split over two frames
        send_seed_frame(8'h20, 8'h00);
        send_seed_frame(8'h20, 8'h20);
        wait_drain("split");
        chk("split_word0",  64'(cap_wr[0]),  64'h0001_0203);
        chk("split_word15", 64'(cap_wr[15]), 64'h3C3D_3E3F);
        chk("split_err",    64'(bus.err),    64'd0);
        done_pulse("split");

        // unknown type is skipped, then a normal load
        w0 = n_wr;
        send_byte(8'h07);
        send_byte(8'h03);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        repeat (3) @(negedge clk);
        chk("unk_no_write", 64'(n_wr - w0), 64'd0);
        chk("unk_err",      64'(bus.err),   64'd1);
        send_seed_frame(8'h40, 8'h80);
        wait_drain("unk_seed");
        done_pulse("unk_seed");

        // overflow: 68 bytes, last 4 dropped during replay
        do_reset();
        w0 = n_wr;
        send_seed_frame(8'h44, 8'h10);
        wait_drain("ovf");
        chk("ovf_writes", 64'(n_wr - w0), 64'd16);
        chk("ovf_err1",   64'(bus.err[1]), 64'd1);
        send_byte(8'h55);
        repeat (3) @(negedge clk);
        chk("ovf_wait_drop", 64'(n_wr - w0), 64'd16);
        done_pulse("ovf");

        // asynchronous reset in the middle of a load
        do_reset();
        send_byte(8'h01);
        send_byte(8'h40);
        for (int i = 0; i < 20; i++) begin
            model_byte(8'(8'h60 + i));
            send_byte(8'(8'h60 + i));
        end
        chk("mid_wr_left", 64'(exp_wr_q.size()), 64'd0);
        chk("mid_busy", 64'(bus.busy), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy",  64'(bus.busy),       64'd0);
        chk("async_wr_en", 64'(bus.seed_wr_en), 64'd0);
        chk("async_addr",  64'(bus.seed_addr),  64'd0);
        chk("async_err",   64'(bus.err),        64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        send_seed_frame(8'h40, 8'hC0);
        wait_drain("after_rst");
        chk("after_rst_word0", 64'(cap_wr[0]), 64'hC0C1_C2C3);
        done_pulse("after_rst");

`ifdef ENCAP_LOADER_TIMEOUT_EN
        // inter-byte timeout inside a seed frame
        do_reset();
        send_byte(8'h01);
        send_byte(8'h40);
        for (int i = 0; i < 5; i++) begin
            model_byte(8'(i));
            send_byte(8'(i));
        end
        repeat (60) @(negedge clk);
        chk("to_err1", 64'(bus.err[1]), 64'd1);
        chk("to_busy", 64'(bus.busy),   64'd0);
        chk("to_wr_left", 64'(exp_wr_q.size()), 64'd0);
        model_clear();
        send_seed_frame(8'h40, 8'h00);
        wait_drain("to_reload");
        done_pulse("to_reload");
`endif

        chk("end_wr_q",   64'(exp_wr_q.size()),   64'd0);
        chk("end_seed_q", 64'(exp_seed_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
